// File: rtl/vec_mul_ctrl.sv
// rtl/vec_mul_ctrl.sv - sequencing controller for a weight-stationary signed PE row
// Loads one weight per PE, then admits a programmed number of input vectors.
module vec_mul_ctrl #(
  parameter int NUM_PE    = 8,
  parameter int WEIGHT_BW = 8,
  parameter int CNT_BW    = 16,
  parameter int PIPE_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_start,
  input  logic                 cfg_reuse,
  input  logic [CNT_BW-1:0]    cfg_num_vec,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [WEIGHT_BW-1:0] w_data,
  output logic [WEIGHT_BW-1:0] pe_weight,
  output logic [NUM_PE-1:0]    pe_weight_reload,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 pe_data_en,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int WCNT_BW = $clog2(NUM_PE);
  localparam logic [WCNT_BW-1:0]  WCNT_LAST = WCNT_BW'(NUM_PE - 1);
  localparam logic [PIPE_LAT-1:0] PIPE_LAST = PIPE_LAT'(1) << (PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [WCNT_BW-1:0]  wcnt;
  logic [CNT_BW-1:0]   vcnt;
  logic [CNT_BW-1:0]   num_q;
  logic [PIPE_LAT-1:0] pipe_q;
  logic [PIPE_LAT-1:0] pipe_nxt;
  logic                w_hs;
  logic                x_hs;
  logic                x_last;
  logic                pipe_last;

  assign w_hs       = w_valid & w_ready;
  assign x_hs       = x_valid & x_ready;
  assign pe_data_en = x_hs;
  assign out_valid  = pipe_q[PIPE_LAT-1];
  assign x_last     = x_hs && (vcnt + CNT_BW'(1) == num_q);

  // Once no more products can enter, the next out_valid is the final one
  // exactly when it is the only bit left in flight.
  assign pipe_nxt  = (pipe_q << 1) | PIPE_LAT'(pe_data_en);
  assign pipe_last = (pipe_nxt == PIPE_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      wcnt             <= '0;
      vcnt             <= '0;
      num_q            <= '0;
      w_ready          <= 1'b0;
      x_ready          <= 1'b0;
      pe_weight        <= '0;
      pe_weight_reload <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      pe_weight_reload <= '0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            num_q <= cfg_num_vec;
            wcnt  <= '0;
            vcnt  <= '0;
            busy  <= 1'b1;
            if (cfg_reuse) begin
              state <= SETTLE;
            end else begin
              state   <= LOAD;
              w_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_hs) begin
            pe_weight        <= w_data;
            pe_weight_reload <= NUM_PE'(1) << wcnt;
            wcnt             <= wcnt + WCNT_BW'(1);
            if (wcnt == WCNT_LAST) begin
              state   <= SETTLE;
              w_ready <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (num_q != '0) begin
            state   <= RUN;
            x_ready <= 1'b1;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (x_hs) begin
            vcnt <= vcnt + CNT_BW'(1);
          end
          if (x_last) begin
            state   <= DRAIN;
            x_ready <= 1'b0;
            done    <= pipe_last;
          end
        end
        DRAIN: begin
          done <= pipe_last;
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mul_ctrl.sv
// tb/tb_vec_mul_ctrl.sv - self-checking bench for vec_mul_ctrl
module tb_vec_mul_ctrl;

  localparam int NP   = 8;
  localparam int WB   = 8;
  localparam int CB   = 16;
  localparam int LAT  = 1;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_reuse = 1'b0;
  logic [CB-1:0] cfg_num_vec = '0;
  logic          w_valid = 1'b0;
  logic [WB-1:0] w_data = '0;
  logic          x_valid = 1'b0;
  logic          w_ready, x_ready, pe_data_en, out_valid, busy, done;
  logic [WB-1:0] pe_weight;
  logic [NP-1:0] pe_weight_reload;

  vec_mul_ctrl #(.NUM_PE(NP), .WEIGHT_BW(WB), .CNT_BW(CB), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_reuse(cfg_reuse),
    .cfg_num_vec(cfg_num_vec), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .pe_weight(pe_weight), .pe_weight_reload(pe_weight_reload), .x_valid(x_valid),
    .x_ready(x_ready), .pe_data_en(pe_data_en), .out_valid(out_valid), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn = 0;

  // stimulus pattern per cycle of one transaction (cycle 0 = start pulse)
  bit          wv[MAXC];
  bit          xv[MAXC];
  bit          sv[MAXC];
  bit [CB-1:0] sn[MAXC];
  bit [WB-1:0] wq[NP];

  // expected timeline
  bit          e_wr[MAXC], e_xr[MAXC], e_ov[MAXC], e_busy[MAXC], e_done[MAXC];
  bit [NP-1:0] e_rl[MAXC];
  bit [WB-1:0] e_ws[MAXC], e_wt[MAXC];
  bit [WB-1:0] cur_w = '0;
  int t_done, t_end, t_firstxr, t_lastbusy;
  int obs_firstxr, obs_done, obs_strobes;

  typedef struct {
    bit          reuse;
    int          num;
    logic [15:0] wpat;
    logic [15:0] xpat;
    logic [63:0] wts;
    int          spur_c;
    int          spur_num;
    int          exp_firstxr;
    int          exp_done;
    int          exp_strobes;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d at %0d: got %h want %h", name, txn, c, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_act();
    return 64'({w_ready, x_ready, pe_data_en, out_valid, busy, done, pe_weight_reload, pe_weight});
  endfunction

  function automatic logic [63:0] pack_exp(input int c);
    return 64'({e_wr[c], e_xr[c], xv[c] & e_xr[c], e_ov[c], e_busy[c], e_done[c], e_rl[c], e_wt[c]});
  endfunction

  // Timeline from the handshake rules: k-th accepted weight strobes PE k a cycle later,
  // one settle cycle, then num accepted vectors each echoed LAT cycles later.
  task automatic build_model(input bit reuse, input int num);
    int c, k, j, settle;
    bit [WB-1:0] wcur;
    for (int i = 0; i < MAXC; i++) begin
      e_wr[i] = 0; e_xr[i] = 0; e_ov[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_rl[i] = '0; e_ws[i] = '0;
    end
    settle = 1;
    if (!reuse) begin
      k = 0;
      c = 1;
      while (k < NP && c < MAXC - 8) begin
        e_wr[c] = 1;
        if (wv[c]) begin
          e_rl[c+1] = NP'(1) << k;
          e_ws[c+1] = wq[k];
          k++;
        end
        c++;
      end
      settle = c;
    end
    for (int i = 1; i <= settle; i++) e_busy[i] = 1;
    if (num == 0) begin
      t_firstxr  = 0;
      t_done     = settle + 1;
      t_lastbusy = settle;
    end else begin
      t_firstxr = settle + 1;
      j = 0;
      c = settle + 1;
      while (j < num && c < MAXC - LAT - 4) begin
        e_xr[c] = 1;
        if (xv[c]) begin
          e_ov[c+LAT] = 1;
          j++;
        end
        c++;
      end
      t_done     = c - 1 + LAT;
      t_lastbusy = t_done;
      for (int i = settle + 1; i <= t_done; i++) e_busy[i] = 1;
    end
    e_done[t_done] = 1;
    t_end = t_done + 3;
    wcur = cur_w;
    for (int i = 0; i < MAXC; i++) begin
      if (e_rl[i] != '0) wcur = e_ws[i];
      e_wt[i] = wcur;
    end
  endtask

  task automatic run_txn(input bit reuse, input int num, input bit rand_spur);
    int widx;
    build_model(reuse, num);
    if (rand_spur) begin
      for (int c = 1; c <= t_lastbusy; c++) begin
        sv[c] = ($urandom_range(0, 5) == 0);
        sn[c] = CB'($urandom);
      end
    end
    widx = 0;
    obs_firstxr = 0;
    obs_done = 0;
    obs_strobes = 0;
    for (int c = 0; c < t_end; c++) begin
      @(posedge clk);
      #1;
      cfg_start   = (c == 0) || sv[c];
      cfg_num_vec = (c == 0) ? CB'(num) : sn[c];
      cfg_reuse   = (c == 0) ? reuse : ~reuse;
      w_valid     = wv[c];
      w_data      = (widx < NP) ? wq[widx] : WB'($urandom);
      x_valid     = xv[c];
      @(negedge clk);
      check("cycle_outputs", c, pack_act(), pack_exp(c));
      if (x_ready && obs_firstxr == 0) obs_firstxr = c;
      if (done && obs_done == 0) obs_done = c;
      if (pe_weight_reload != '0) obs_strobes++;
      if (w_valid && w_ready) widx++;
    end
    cfg_start = 0;
    w_valid = 0;
    x_valid = 0;
    cur_w = e_wt[t_end-1];
    txn++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 4, 16'hFFFF, 16'hFFFF, 64'h0807060504030201, 11, 7, 10, 14, 8};
    tbl[1] = '{1'b0, 2, 16'hAAAA, 16'hFFFF, 64'hF909007FFF038005, 5, 9, 17, 19, 8};
    tbl[2] = '{1'b1, 3, 16'hFFFF, 16'hFFF7, 64'h0, 3, 1, 2, 6, 0};
    tbl[3] = '{1'b1, 0, 16'hFFFF, 16'hFFFF, 64'h0, 1, 5, 0, 2, 0};
    tbl[4] = '{1'b0, 1, 16'hFFFF, 16'hFFFF, 64'h1122334455667788, 0, 0, 10, 11, 8};

    #12;
    check("reset_outputs", 0, pack_act(), 64'h0);
    @(posedge clk);
    #1;
    rstn = 1;

    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < MAXC; c++) begin
        wv[c] = tbl[i].wpat[c % 16];
        xv[c] = tbl[i].xpat[c % 16];
        sv[c] = (c != 0) && (c == tbl[i].spur_c);
        sn[c] = CB'(tbl[i].spur_num);
      end
      for (int k = 0; k < NP; k++) wq[k] = tbl[i].wts[8*k +: 8];
      run_txn(tbl[i].reuse, tbl[i].num, 1'b0);
      check("first_xready", i, obs_firstxr, tbl[i].exp_firstxr);
      check("done_cycle", i, obs_done, tbl[i].exp_done);
      check("strobe_count", i, obs_strobes, tbl[i].exp_strobes);
    end

    for (int r = 0; r < 25; r++) begin
      int wd, xd;
      wd = $urandom_range(30, 100);
      xd = $urandom_range(30, 100);
      for (int c = 0; c < MAXC; c++) begin
        wv[c] = ($urandom_range(0, 99) < wd) || (c % 4 == 3);
        xv[c] = ($urandom_range(0, 99) < xd) || (c % 4 == 1);
        sv[c] = 0;
        sn[c] = '0;
      end
      for (int k = 0; k < NP; k++) wq[k] = WB'($urandom);
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'b1);
    end

    // asynchronous reset in the middle of a weight load
    @(posedge clk);
    #1;
    cfg_start = 1; cfg_reuse = 0; cfg_num_vec = 5; w_valid = 0;
    @(posedge clk);
    #1;
    cfg_start = 0; w_valid = 1; w_data = 8'h11;
    @(posedge clk);
    #1;
    w_data = 8'h22;
    @(posedge clk);
    #1;
    w_data = 8'h33;
    @(posedge clk);
    #1;
    w_valid = 0;
    @(negedge clk);
    check("pre_reset_strobe", 4, {busy, w_ready, pe_weight_reload, pe_weight}, {1'b1, 1'b1, 8'h04, 8'h33});
    #1;
    rstn = 0;
    #1;
    check("async_reset", 0, pack_act(), 64'h0);
    @(posedge clk);
    #2;
    rstn = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      w_valid = 1;
      w_data = 8'h77;
      @(negedge clk);
      check("post_reset_idle", c, pack_act(), 64'h0);
    end
    w_valid = 0;
    cur_w = '0;

    for (int k = 0; k < NP; k++) wq[k] = WB'($urandom);
    for (int c = 0; c < MAXC; c++) begin
      wv[c] = 1; xv[c] = (c % 3 != 0); sv[c] = 0; sn[c] = '0;
    end
    run_txn(1'b1, 3, 1'b0);
    run_txn(1'b0, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mul_ctrl.md
# vec_mul_ctrl

Sequencing controller for a row of NUM_PE signed weight-stationary PE_vec multipliers. It loads one weight per PE from a serial valid/ready stream by broadcasting the weight and pulsing a one-hot per-PE reload strobe. It then admits a programmed number of input vectors through a valid/ready handshake and marks which cycles carry valid PE products downstream. The block sits between the host/DMA front end and the PE row plus its reduction stage. It never touches the data path itself.

## Interface
- NUM_PE, 8, number of PEs in the row (≥2)
- WEIGHT_BW, 8, signed weight width, matches the PE weight port
- CNT_BW, 16, width of the vector-count configuration
- PIPE_LAT, 1, cycles from a PE product to a valid reduced result downstream (≥1)

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
- cfg_reuse  in  1  sampled with cfg_start; 1 = skip weight load, reuse resident weights
- cfg_num_vec  in  CNT_BW  vectors to stream; latched on accepted cfg_start
- w_valid  in  1  weight stream valid
- w_ready  out  1  weight stream ready
- w_data  in  WEIGHT_BW  signed weight; the k-th accepted weight goes to PE k
- pe_weight  out  WEIGHT_BW  registered weight broadcast to all PE weight inputs
- pe_weight_reload  out  NUM_PE  registered one-hot reload strobe, bit k = PE k
- x_valid  in  1  input-vector valid (vector bus goes to the PEs directly)
- x_ready  out  1  input-vector ready
- pe_data_en  out  1  combinational x_valid & x_ready; PE products valid this cycle
- out_valid  out  1  pe_data_en delayed PIPE_LAT cycles
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DRAIN.
- IDLE: when cfg_start=1, latch cfg_num_vec into num_q and clear counters. Go to LOAD if cfg_reuse=0, otherwise to SETTLE.
- LOAD: w_ready=1.
  - On each w handshake, the next cycle has pe_weight=w_data and pe_weight_reload=1<<wcnt, then wcnt increments.
  - Cycles without a handshake have pe_weight_reload=0 and pe_weight holds its value.
  - After the NUM_PE-th handshake, go to SETTLE.
- SETTLE: exactly one cycle, while the last reload strobe is captured by its PE weight register. w_ready=0 and x_ready=0.
  - Next state is RUN if num_q≠0.
  - If num_q=0, assert done and go to IDLE.
- RUN: x_ready=1. Each x handshake increments vcnt. The handshake that makes vcnt==num_q moves to DRAIN on the next cycle, and x_ready=0 from then on.
- DRAIN: hold until the last out_valid has been emitted. done is asserted in the same cycle as the final out_valid, then the next state is IDLE.
- out_valid pipeline: PIPE_LAT-deep shift register fed by pe_data_en. It runs in every state so in-flight products always drain.
- Counters: wcnt is clog2(NUM_PE) bits. vcnt is CNT_BW bits and compares for equality only, so there is no wrap-around.
- cfg_start outside IDLE is ignored; the latched configuration does not change.
- w_valid outside LOAD and x_valid outside RUN are never acknowledged.
- A weight beat offered after the NUM_PE-th is not accepted (w_ready=0 from SETTLE on).
- Reset (any state, asynchronous): state=IDLE and all counters 0. All outputs 0: w_ready, x_ready, pe_weight, pe_weight_reload, out_valid pipeline, done, busy.
  - PE weight registers are not cleared by this block; they follow their own rstn.
  - cfg_reuse=1 after reset therefore runs on whatever weights the PEs hold.

## Timing
- A w handshake in cycle t gives the reload strobe in cycle t+1. PE k holds the weight from cycle t+2.
- Minimum load time: NUM_PE cycles of handshakes, plus 1 SETTLE cycle. The first x_ready is then in the cycle after SETTLE.
- First x_ready after cfg_start:
  - cfg_reuse=1: start cycle + 2.
  - cfg_reuse=0 with back-to-back weights: start cycle + NUM_PE + 2.
- x handshake in cycle t gives out_valid in cycle t+PIPE_LAT.
- done coincides with out_valid for vector num_q. busy drops in the following cycle.
- The next cfg_start is accepted from the first cycle that busy=0.
- No combinational path from inputs to ready outputs. pe_data_en is the only combinational output.

## Test plan
- Reset mid-LOAD after 3 weights → all outputs 0 in the same cycle as rstn low. After release, busy=0 and the first w_valid is not acknowledged.
- NUM_PE=8, cfg_reuse=0, weights 1..8 sent back-to-back, num_vec=4, x_valid held high:
  - pe_weight_reload walks 0x01→0x80 on consecutive cycles with the matching pe_weight.
  - One SETTLE cycle follows, then 4 consecutive pe_data_en.
  - out_valid shows 4 pulses delayed PIPE_LAT, and done coincides with the 4th.
- Weight stream with w_valid toggling every other cycle → exactly 8 strobes and no strobe in gap cycles. Weights 5 and −128 land on the correct PE bits.
- cfg_reuse=1, num_vec=3, x_valid pattern 1,0,1,1 → x handshakes in 3 cycles, x_ready drops after the 3rd, done after the 3rd out_valid. No reload strobes at any point.
- cfg_num_vec=0 with cfg_reuse=1 → done 2 cycles after start, no x_ready, no out_valid.
- cfg_start pulsed during RUN with different num_vec → ignored; the original count completes and busy stays high until done.
